// File: rtl/cfg_cell_pkg.sv
// Shared definitions for the configurable logic cell family: FSM state
// encoding, output-mode encoding and configuration-word sizing.
package cfg_cell_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } cfg_state_e;

  localparam logic MODE_COMB = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  // Truth table of a K-input LUT plus one mode bit.
  function automatic int cfg_width(input int k);
    return (1 << k) + 1;
  endfunction

endpackage

// File: rtl/lut_read.sv
// Combinational LUT_W:1 selector: returns the truth-table entry addressed by sel_i.
module lut_read #(
  parameter  int K     = 4,
  localparam int LUT_W = 2 ** K
) (
  input  logic [LUT_W-1:0] lut_i,
  input  logic [K-1:0]     sel_i,
  output logic             bit_o
);

  assign bit_o = lut_i[sel_i];

endmodule

// File: rtl/cfg_logic_cell.sv
// K-input LUT cell loaded through a serial valid/ready configuration chain,
// with a combinational or clock-enabled registered output.
module cfg_logic_cell
  import cfg_cell_pkg::*;
#(
  parameter  int K     = 4,
  localparam int LUT_W = 2 ** K,
  localparam int CFG_W = cfg_width(K),
  localparam int CNT_W = $clog2(CFG_W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         cfg_out,
  input  logic [K-1:0] in,
  input  logic         ce,
  output logic         out,
  output logic [1:0]   state_o
);

  localparam logic [1:0] ST_UNCONF = UNCONF;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

  // Handshake: a config bit transfers on a rising clk edge where
  // cfg_valid && cfg_ready && !cfg_start; cfg_ready is high only in LOAD,
  // and a same-cycle cfg_start discards the offered bit.

  logic [1:0]       state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_out_q, cfg_out_d;
  logic             q_q, q_d;

  logic             accept;
  logic             comb_bit;
  logic [LUT_W-1:0] lut;
  logic             mode;

  assign lut    = cfg_q[LUT_W-1:0];
  assign mode   = cfg_q[LUT_W];
  assign accept = cfg_valid && (state_q == ST_LOAD) && !cfg_start;

  lut_read #(.K(K)) u_lut_read (
    .lut_i (lut),
    .sel_i (in),
    .bit_o (comb_bit)
  );

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    cfg_out_d = cfg_out_q;
    q_d       = q_q;
    if (cfg_start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      q_d     = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            cfg_d     = {cfg_bit, cfg_q[CFG_W-1:1]};
            cfg_out_d = cfg_q[0];
            // Counter parks on the last index instead of wrapping.
            if (cnt_q == CNT_LAST) begin
              state_d = ST_ACTIVE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if ((mode == MODE_REG) && ce) begin
            q_d = comb_bit;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_UNCONF;
      cfg_q     <= '0;
      cnt_q     <= '0;
      cfg_out_q <= 1'b0;
      q_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      cfg_out_q <= cfg_out_d;
      q_q       <= q_d;
    end
  end

  always_comb begin
    out = 1'b0;
    if (state_q == ST_ACTIVE) begin
      out = (mode == MODE_REG) ? q_q : comb_bit;
    end
  end

  assign cfg_ready = (state_q == ST_LOAD);
  assign cfg_done  = (state_q == ST_ACTIVE);
  assign cfg_out   = cfg_out_q;
  assign state_o   = state_q;

endmodule

// File: doc/cfg_logic_cell.md
Name: cfg_logic_cell

Overview:
- Parametrised successor to the fixed 4-data/2-select logic cell used in the programmable fabric.
- A K-input LUT whose truth table and output mode are loaded through a serial configuration chain with a valid/ready handshake.
- The output is either combinational or registered, with a clock enable.
- Cells daisy-chain via cfg_out to form the neural-network fabric's configuration scan path.

Parameters:
- K, 4, number of LUT inputs; legal range 2..6.
- LUT_W, 2**K, truth-table width (derived; do not override).
- CFG_W, LUT_W+1, configuration word width: truth table plus 1 mode bit (derived).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse: begin (re)configuration.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial configuration data, LSB of config word first.
- cfg_ready  output  1  cell accepts a config bit this cycle.
- cfg_done  output  1  level: cell holds a complete, valid configuration.
- cfg_out  output  1  registered chain output (bit shifted out of config register).
- in  input  K  LUT address inputs.
- ce  input  1  clock enable for the registered output path.
- out  output  1  cell output.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=UNCONF; cfg register=0; bit counter=0; q=0.
  - cfg_ready=0, cfg_done=0, cfg_out=0, out=0.
- States: UNCONF, LOAD, ACTIVE.
  - Any state + cfg_start → LOAD next cycle; counter←0, cfg_done←0, q←0.
  - cfg_start wins over a same-cycle cfg_valid; that bit is dropped.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: cfg ← {cfg_bit, cfg[CFG_W-1:1]}; cfg_out ← old cfg[0]; counter+1.
  - cfg_valid gaps are allowed; state is held.
  - On the accept with counter==CFG_W-1: → ACTIVE next cycle with cfg_done=1, cfg_ready=0.
  - The first bit sent lands in cfg[0]; the last bit sent is the mode bit cfg[CFG_W-1].
- Field mapping: lut=cfg[LUT_W-1:0], mode=cfg[LUT_W] (0=combinational, 1=registered).
- ACTIVE:
  - comb = lut[in].
  - mode=0: out=comb, zero cycle latency.
  - mode=1: q←comb on edges with ce=1; q held when ce=0; out=q (1-cycle latency).
  - cfg_bit and cfg_valid are ignored; cfg_out holds its value.
- out=0 whenever state≠ACTIVE, including the whole of LOAD.
- cfg_out changes only on accepted bits. Shifting CFG_W new bits pushes out the previous configuration, LSB first.
- Reset mid-LOAD: discards the partial load, returns to UNCONF, clears the config register.
- Counter width is clog2(CFG_W+1). The counter never wraps: it stops at CFG_W-1 and the state leaves LOAD.
- No X propagation: every output is driven in every state.

Decomposition:
- Shared package cfg_cell_pkg holds:
  - the state enum (UNCONF, LOAD, ACTIVE);
  - localparams for mode encoding (MODE_COMB=0, MODE_REG=1);
  - a constant function returning CFG_W for a given K.
- One natural sub-module: lut_read (param K), a purely combinational LUT_W:1 selector of lut by in. It is reusable by later multi-output cells.

Test Plan:
1. K=4, after rst: shift 17 bits encoding lut=16'h8000, mode=0 → cfg_done=1 the cycle after the 17th accept. in=4'hF → out=1 same cycle; in=4'hE → out=0.
2. Load lut=16'h6996, mode=1. in=4'h1, ce=1 → out=0 this cycle, 1 next edge. Then ce=0 with in=4'h3 → out stays 1. ce=1 → out=0.
3. Handshake gaps: 17 bits with cfg_valid low every other cycle → counter advances only on accepts; cfg_done rises after the 17th accepted bit.
4. Restart: after 8 accepted bits, pulse cfg_start together with cfg_valid=1 → bit dropped, counter=0, cfg_done=0, out=0. Full 17 new bits are required before cfg_done=1.
5. Chain readout: configured with 16'h8000/mode 0, start a reload and shift 17 zeros → cfg_out emits 0×15, 1, 0 in order. out=0 throughout LOAD.
6. Assert rst during LOAD after 10 bits → next cycle state UNCONF, cfg_ready=0, cfg_done=0, cfg_out=0, out=0 for any in.
